matrix_scan_driver: RTL and testbench

- Physical-display end of the fan status path. Accepts a 64-bit dot-matrix frame plus two BCD digits (battery level) from the control logic.
- Time-multiplexes them onto an 8x8 LED matrix (row/column lines) and a 2-digit 7-segment display.
- Double-buffers frames with a load/ack handshake so the image only changes on frame boundaries, and inserts a blanking interval per row to suppress ghosting.

---
 rtl/matrix_scan_driver.sv | 129 ++++++++++++
 tb/tb_matrix_scan_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_driver.sv
// Drives an 8x8 LED matrix and a 2-digit 7-segment display from one row-slot timer.
// Frames are double-buffered and swap only on frame boundaries. Each row slot starts with a blanking interval.
module matrix_scan_driver #(
   parameter int ROW_TICKS   = 1000,
   parameter int BLANK_TICKS = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] frame_in,
   input  logic        frame_load,
   output logic        frame_ack,
   input  logic [3:0]  bcd_hi,
   input  logic [3:0]  bcd_lo,
   output logic [7:0]  row,
   output logic [7:0]  col,
   output logic [7:0]  seg,
   output logic [1:0]  dig_sel
);

   localparam int TW = (ROW_TICKS > 2) ? $clog2(ROW_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(ROW_TICKS - 1);

   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    row_idx_q, row_idx_d;
   logic [63:0]   active_q, active_d;
   logic [63:0]   pending_q, pending_d;
   logic          pend_q, pend_d;
   logic [7:0]    digits_q, digits_d;
   logic          ack_q, ack_d;
   logic [7:0]    row_q, row_d;
   logic [7:0]    col_q, col_d;
   logic [7:0]    seg_q, seg_d;
   logic [1:0]    dig_q, dig_d;
   logic          wrap, boundary, lit;

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'h3F;
         4'd1:    s = 8'h06;
         4'd2:    s = 8'h5B;
         4'd3:    s = 8'h4F;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'h6D;
         4'd6:    s = 8'h7D;
         4'd7:    s = 8'h07;
         4'd8:    s = 8'h7F;
         4'd9:    s = 8'h6F;
         default: s = 8'h40;
      endcase
      return s;
   endfunction

   always_comb begin
      wrap      = (tick_q == TICK_LAST);
      boundary  = wrap && (row_idx_q == 3'd7);
      tick_d    = wrap ? '0 : tick_q + TW'(1);
      row_idx_d = wrap ? row_idx_q + 3'd1 : row_idx_q;

      // Promotion reads the pending buffer as it stood before this cycle's load.
      active_d  = active_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      ack_d     = boundary && pend_q;
      if (boundary && pend_q) begin
         active_d = pending_q;
         pend_d   = 1'b0;
      end
      if (frame_load) begin
         pending_d = frame_in;
         pend_d    = 1'b1;
      end

      // The slot's first tick already displays the freshly sampled digits.
      digits_d = (tick_q == '0) ? {bcd_hi, bcd_lo} : digits_q;
      lit      = !(int'(tick_q) < BLANK_TICKS);

      row_d = 8'hFF;
      col_d = 8'h00;
      seg_d = 8'h00;
      dig_d = 2'b00;
      if (lit) begin
         row_d = ~(8'b1 << row_idx_q);
         col_d = active_q[{row_idx_q, 3'b000} +: 8];
         if (row_idx_q[0]) begin
            dig_d = 2'b10;
            seg_d = seg_decode(digits_d[7:4]);
         end else begin
            dig_d = 2'b01;
            seg_d = seg_decode(digits_d[3:0]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q    <= '0;
         row_idx_q <= 3'd0;
         active_q  <= 64'd0;
         pending_q <= 64'd0;
         pend_q    <= 1'b0;
         digits_q  <= 8'd0;
         ack_q     <= 1'b0;
         row_q     <= 8'hFF;
         col_q     <= 8'h00;
         seg_q     <= 8'h00;
         dig_q     <= 2'b00;
      end else begin
         tick_q    <= tick_d;
         row_idx_q <= row_idx_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         pend_q    <= pend_d;
         digits_q  <= digits_d;
         ack_q     <= ack_d;
         row_q     <= row_d;
         col_q     <= col_d;
         seg_q     <= seg_d;
         dig_q     <= dig_d;
      end
   end

   assign frame_ack = ack_q;
   assign row       = row_q;
   assign col       = col_q;
   assign seg       = seg_q;
   assign dig_sel   = dig_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with ROW_TICKS=8 and BLANK_TICKS=2.
// cyc counts clock edges since reset release; after edge k, the outputs reflect counter state k-1.
module tb_matrix_scan_driver;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] frame_in;
   logic        frame_load;
   logic        frame_ack;
   logic [3:0]  bcd_hi, bcd_lo;
   logic [7:0]  row, col, seg;
   logic [1:0]  dig_sel;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   matrix_scan_driver #(.ROW_TICKS(8), .BLANK_TICKS(2)) dut (
      .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_load(frame_load),
      .frame_ack(frame_ack), .bcd_hi(bcd_hi), .bcd_lo(bcd_lo),
      .row(row), .col(col), .seg(seg), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic wait_cyc(input int target);
      if (cyc > target) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_cyc: now %0d target %0d", cyc, target);
      end
      while (cyc < target) @(negedge clk);
   endtask

   task automatic load(input logic [63:0] f);
      frame_in   = f;
      frame_load = 1'b1;
      @(negedge clk);
      frame_load = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; frame_load = 1'b1; frame_in = '1; bcd_hi = 4'd0; bcd_lo = 4'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({row, col, seg, dig_sel, frame_ack} !== {8'hFF, 8'h00, 8'h00, 2'b00, 1'b0}) begin
         n_fail++; $display("FAIL reset_init: got %h %h %h %b %b", row, col, seg, dig_sel, frame_ack);
      end
      frame_load = 1'b0;
      rst_n = 1'b1;
      wait_cyc(2);
      n_checks++;
      if (row !== 8'hFF) begin n_fail++; $display("FAIL blank_after_rst: row %h exp FF", row); end
      wait_cyc(3);
      n_checks++;
      if ({row, col, seg, dig_sel} !== {8'hFE, 8'h00, 8'h3F, 2'b01}) begin
         n_fail++; $display("FAIL first_lit: got %h %h %h %b exp FE 00 3F 01", row, col, seg, dig_sel);
      end
      wait_cyc(20);
      load('1);
      wait_cyc(30);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({row, col, seg, dig_sel, frame_ack} !== {8'hFF, 8'h00, 8'h00, 2'b00, 1'b0}) begin
         n_fail++; $display("FAIL reset_mid: got %h %h %h %b %b", row, col, seg, dig_sel, frame_ack);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(64);
      n_checks++;
      if (frame_ack !== 1'b0) begin n_fail++; $display("FAIL discard_ack: got %b exp 0", frame_ack); end
      wait_cyc(69);
      n_checks++;
      if (col !== 8'h00) begin n_fail++; $display("FAIL discard_col: got %h exp 00", col); end
   endtask

   task automatic test_scan;
      int pulses = 0;
      logic [7:0] er, ec;
      wait_cyc(70);
      load(64'h8040201008040201);
      for (int k = 72; k <= 140; k++) begin
         wait_cyc(k);
         if (frame_ack === 1'b1) pulses++;
         if (k == 128) begin
            n_checks++;
            if (frame_ack !== 1'b1) begin n_fail++; $display("FAIL scan_ack_at_boundary: got %b exp 1", frame_ack); end
         end
      end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL scan_ack_pulses: got %0d exp 1", pulses); end
      // Re-check the full frame 128..191 (output lags state by one cycle).
      for (int s = 128; s <= 191; s++) begin
         int t = s % 8;
         int r = (s / 8) % 8;
         if (t < 2) begin er = 8'hFF; ec = 8'h00; end
         else begin er = ~(8'h01 << r); ec = 8'h01 << r; end
         if (s + 1 > 141) wait_cyc(s + 1);
         else continue;
         n_checks++;
         if ({row, col} !== {er, ec}) begin
            n_fail++; $display("FAIL scan_s%0d: row/col %h/%h exp %h/%h", s, row, col, er, ec);
         end
      end
   endtask

   task automatic test_scan_frame2;
      logic [7:0] er, ec;
      // The loaded frame stays active, so the next frame scans identically.
      for (int s = 192; s <= 255; s++) begin
         int t = s % 8;
         int r = (s / 8) % 8;
         if (t < 2) begin er = 8'hFF; ec = 8'h00; end
         else begin er = ~(8'h01 << r); ec = 8'h01 << r; end
         wait_cyc(s + 1);
         n_checks++;
         if ({row, col} !== {er, ec}) begin
            n_fail++; $display("FAIL scan_s%0d: row/col %h/%h exp %h/%h", s, row, col, er, ec);
         end
      end
   endtask

   task automatic test_latest_wins;
      logic [63:0] fa = 64'hAAAA_AAAA_AAAA_AAAA;
      logic [63:0] fb = 64'h0123_4567_89AB_CDEF;
      int pulses = 0;
      wait_cyc(260);
      load(fa);
      wait_cyc(270);
      load(fb);
      for (int k = 272; k <= 330; k++) begin
         wait_cyc(k);
         if (frame_ack === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL latest_pulses: got %0d exp 1", pulses); end
      for (int r = 0; r < 8; r++) begin
         wait_cyc(384 + 8 * r + 5);
         n_checks++;
         if (col !== fb[8*r +: 8]) begin
            n_fail++; $display("FAIL latest_row%0d: col %h exp %h", r, col, fb[8*r +: 8]);
         end
      end
   endtask

   task automatic test_simul_load;
      logic [63:0] fc = 64'hF0E1_D2C3_B4A5_9687;
      logic [63:0] fd = 64'h1122_3344_5566_7788;
      wait_cyc(450);
      load(fc);
      wait_cyc(511);
      load(fd);
      n_checks++;
      if (frame_ack !== 1'b1) begin n_fail++; $display("FAIL simul_ack1: got %b exp 1", frame_ack); end
      wait_cyc(513);
      n_checks++;
      if (frame_ack !== 1'b0) begin n_fail++; $display("FAIL simul_ack1_len: got %b exp 0", frame_ack); end
      for (int r = 0; r < 8; r++) begin
         wait_cyc(512 + 8 * r + 5);
         n_checks++;
         if (col !== fc[8*r +: 8]) begin
            n_fail++; $display("FAIL simul_c_row%0d: col %h exp %h", r, col, fc[8*r +: 8]);
         end
      end
      wait_cyc(576);
      n_checks++;
      if (frame_ack !== 1'b1) begin n_fail++; $display("FAIL simul_ack2: got %b exp 1", frame_ack); end
      for (int r = 0; r < 8; r++) begin
         wait_cyc(576 + 8 * r + 5);
         n_checks++;
         if (col !== fd[8*r +: 8]) begin
            n_fail++; $display("FAIL simul_d_row%0d: col %h exp %h", r, col, fd[8*r +: 8]);
         end
      end
   endtask

   task automatic test_seg;
      wait_cyc(642);
      bcd_hi = 4'd4; bcd_lo = 4'd2;
      // state 648 -> row 1 (odd, tens); 656 -> row 2 (even, units)
      wait_cyc(653);
      n_checks++;
      if ({dig_sel, seg} !== {2'b10, 8'h66}) begin
         n_fail++; $display("FAIL seg_tens: dig/seg %b/%h exp 10/66", dig_sel, seg);
      end
      wait_cyc(657);
      n_checks++;
      if ({dig_sel, seg} !== {2'b00, 8'h00}) begin
         n_fail++; $display("FAIL seg_blank: dig/seg %b/%h exp 00/00", dig_sel, seg);
      end
      wait_cyc(661);
      n_checks++;
      if ({dig_sel, seg} !== {2'b01, 8'h5B}) begin
         n_fail++; $display("FAIL seg_units: dig/seg %b/%h exp 01/5B", dig_sel, seg);
      end
      wait_cyc(662);
      bcd_lo = 4'd12;
      // state 672 -> row 4 (even)
      wait_cyc(677);
      n_checks++;
      if ({dig_sel, seg} !== {2'b01, 8'h40}) begin
         n_fail++; $display("FAIL seg_dash: dig/seg %b/%h exp 01/40", dig_sel, seg);
      end
   endtask

   task automatic test_digit_latch;
      // Slot at state 688 is row 6 (even); change units at tick 3.
      wait_cyc(691);
      bcd_lo = 4'd7;
      for (int k = 692; k <= 696; k++) begin
         wait_cyc(k);
         n_checks++;
         if (seg !== 8'h40) begin n_fail++; $display("FAIL latch_hold_c%0d: seg %h exp 40", k, seg); end
      end
      wait_cyc(705);
      n_checks++;
      if (seg !== 8'h00) begin n_fail++; $display("FAIL latch_blank: seg %h exp 00", seg); end
      wait_cyc(707);
      n_checks++;
      if ({dig_sel, seg} !== {2'b01, 8'h07}) begin
         n_fail++; $display("FAIL latch_new: dig/seg %b/%h exp 01/07", dig_sel, seg);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_scan_frame2();
      test_latest_wins();
      test_simul_load();
      test_seg();
      test_digit_latch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
